pipe_ctrl_unit: RTL and testbench
=================================

// Module: pipe_ctrl_unit
// PURPOSE
//  Parametrised pipeline control unit: merges per-stage stall requests and exception causes
//  into the stall vector, flush pulse and redirect PC for every pipeline register.
//  Sits beside the datapath; takes the cause word from MEM/commit and EPC from CP0.
//  Adds over the previous generation:
//   - N-stage generic stall prefix
//   - multi-cycle flush hold with cause capture
//   - defined default vector for unknown causes
//   - optional stall watchdog
// PARAMETERS
//  NUM_STAGES    6             pipeline registers controlled (stall_o width)
//  DATA_W        32            PC / EPC width
//  EXC_VECTOR    32'h00400004  redirect target for every non-ERET cause
//  FLUSH_CYCLES  1             cycles flush_o stays high per exception (>=1)
//  STALL_TIMEOUT 1024          watchdog threshold, consecutive stalled cycles (>=2)
// PORTS
//  clk              in   1           rising-edge clock
//  rst              in   1           synchronous, active-high reset
//  excepttype_i     in   32          cause word; 0 = none; 32'h0000000e = ERET
//  cp0_epc_i        in   DATA_W      EPC from CP0, used on ERET
//  stallreq_i       in   NUM_STAGES  bit k = stage k requests stall of stages 0..k
//  stall_o          out  NUM_STAGES  bit j high = hold pipeline register j
//  flush_o          out  1           clear all pipeline registers
//  new_pc_o         out  DATA_W      redirect PC, valid while flush_o high, else 0
//  busy_o           out  1           flush-hold FSM not in RUN
//  exc_cause_o      out  32          cause of last accepted exception (registered)
//  stall_timeout_o  out  1           sticky watchdog flag (0 when macro off)
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state=RUN, hold counter=0, exc_cause_o=0, watchdog cleared.
//    Outputs are gated while rst=1: stall_o=0, flush_o=0, new_pc_o=0, busy_o=0.
//  - RUN, excepttype_i!=0: exception accepted same cycle (combinational).
//      - flush_o=1, stall_o=0.
//      - new_pc_o = cp0_epc_i if cause==32'h0000000e, else EXC_VECTOR (including unknown codes).
//      - Next edge: exc_cause_o<=excepttype_i and the redirect PC is latched.
//      - FLUSH_CYCLES>1: go to FLUSH with cnt<=FLUSH_CYCLES-1; otherwise stay in RUN.
//  - FLUSH state: flush_o=1, stall_o=0, new_pc_o=latched PC, busy_o=1.
//      - excepttype_i and stallreq_i are ignored.
//      - cnt decrements each cycle; go to RUN on the edge where cnt==1.
//  - RUN, excepttype_i==0: flush_o=0, new_pc_o=0.
//      - stall_o[j] = |stallreq_i[NUM_STAGES-1:j].
//      - Exception outranks every stall request.
//  - stall_o is always a contiguous prefix of ones from bit 0 (e.g. 6'b001111).
//  - Exception one cycle after FLUSH ends is accepted normally; no dead cycle.
//  - rst asserted mid-FLUSH aborts the hold; the next cycle is RUN.
// CONFIGURATION
//  PIPE_CTRL_WATCHDOG_EN defined:
//   - wd_cnt counts consecutive cycles with |stall_o.
//   - wd_cnt clears on any cycle with stall_o==0 or flush_o==1; saturates at STALL_TIMEOUT.
//   - stall_timeout_o<=1 on the edge wd_cnt reaches STALL_TIMEOUT; sticky until rst.
//  PIPE_CTRL_WATCHDOG_EN undefined:
//   - No counter is built; stall_timeout_o tied to 0.
// STRUCTURE
//  Shared defines file:
//   - RstEnable, ZeroWord, Stop
//   - cause codes EXC_INT=1, EXC_SYS=8, EXC_INV=0xa, EXC_OV=0xc, EXC_TRAP=0xd, EXC_ERET=0xe
//   - FSM encodings ST_RUN / ST_FLUSH
//  Sub-module stall_prefix: purely combinational OR-suffix of stallreq_i, parametrised by
//   NUM_STAGES. FSM, counters and PC select live in the top module.
// TESTING
//  1. Reset: hold rst 3 cycles with stallreq_i=6'b111111, excepttype_i=1
//     -> all outputs 0, busy_o=0.
//  2. Stall prefix: stallreq_i=6'b001000 -> stall_o=6'b001111;
//     stallreq_i=6'b000100 -> 6'b000111; both set -> 6'b001111; 0 -> 0.
//  3. Redirect: excepttype_i=8 with stallreq_i=6'b001000
//     -> same cycle flush_o=1, stall_o=0, new_pc_o=32'h00400004; next cycle exc_cause_o=8.
//     excepttype_i=32'h0e, cp0_epc_i=32'h00400120 -> new_pc_o=32'h00400120.
//     excepttype_i=32'h55 -> new_pc_o=32'h00400004.
//  4. FLUSH_CYCLES=3: excepttype_i=1 for one cycle -> flush_o high exactly 3 cycles, busy_o high
//     cycles 2-3. A second cause (0xc) in cycle 2 is ignored: exc_cause_o stays 1.
//     A cause in cycle 4 is accepted.
//  5. Reset mid-hold: FLUSH_CYCLES=4, rst asserted in second flush cycle
//     -> next cycle flush_o=0, busy_o=0, exc_cause_o=0.
//  6. Watchdog (macro on, STALL_TIMEOUT=8):
//     - stallreq_i=6'b000100 held 8 cycles -> stall_timeout_o=1 after edge 8, stays 1 after release.
//     - 7 stalled cycles, a gap, 7 more -> stays 0.
//     - Macro off -> stays 0.

Source files
------------

// File: rtl/pipe_ctrl_unit_pkg.sv
// rtl/pipe_ctrl_unit_pkg.sv - shared constants, cause codes and FSM encoding for pipe_ctrl_unit
package pipe_ctrl_unit_pkg;

   localparam logic        RstEnable = 1'b1;
   localparam logic [31:0] ZeroWord  = 32'h0000_0000;
   localparam logic        Stop      = 1'b1;

   typedef enum logic [31:0] {
      EXC_NONE = 32'h0000_0000,
      EXC_INT  = 32'h0000_0001,
      EXC_SYS  = 32'h0000_0008,
      EXC_INV  = 32'h0000_000a,
      EXC_OV   = 32'h0000_000c,
      EXC_TRAP = 32'h0000_000d,
      EXC_ERET = 32'h0000_000e
   } exc_code_e;

   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } pipe_state_e;

   function automatic logic is_eret(input logic [31:0] cause);
      return cause == EXC_ERET;
   endfunction

endpackage

// File: rtl/pipe_ctrl_unit_stall_prefix.sv
// rtl/pipe_ctrl_unit_stall_prefix.sv - OR-suffix of stall requests into a contiguous stall prefix
module pipe_ctrl_unit_stall_prefix
   import pipe_ctrl_unit_pkg::*;
#(
   parameter int NUM_STAGES = 6
) (
   input  logic [NUM_STAGES-1:0] stallreq_i,
   output logic [NUM_STAGES-1:0] stall_o
);

   // a request at stage k holds every register at or below k, so bit j sees requests from j upwards
   always_comb begin
      logic acc;
      acc     = 1'b0;
      stall_o = '0;
      for (int j = NUM_STAGES - 1; j >= 0; j--) begin
         acc        = acc | stallreq_i[j];
         stall_o[j] = acc ? Stop : 1'b0;
      end
   end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// rtl/pipe_ctrl_unit.sv - pipeline stall/flush/redirect control; stall watchdog under PIPE_CTRL_WATCHDOG_EN
module pipe_ctrl_unit
   import pipe_ctrl_unit_pkg::*;
#(
   parameter int                NUM_STAGES    = 6,
   parameter int                DATA_W        = 32,
   parameter logic [DATA_W-1:0] EXC_VECTOR    = 'h0040_0004,
   parameter int                FLUSH_CYCLES  = 1,
   parameter int                STALL_TIMEOUT = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           excepttype_i,
   input  logic [DATA_W-1:0]     cp0_epc_i,
   input  logic [NUM_STAGES-1:0] stallreq_i,
   output logic [NUM_STAGES-1:0] stall_o,
   output logic                  flush_o,
   output logic [DATA_W-1:0]     new_pc_o,
   output logic                  busy_o,
   output logic [31:0]           exc_cause_o,
   output logic                  stall_timeout_o
);

   localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   pipe_state_e         state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   pc_q, pc_d;
   logic [31:0]         cause_q, cause_d;
   logic [NUM_STAGES-1:0] stall_prefix;
   logic [DATA_W-1:0]   redirect_pc;

   pipe_ctrl_unit_stall_prefix #(
      .NUM_STAGES (NUM_STAGES)
   ) u_stall_prefix (
      .stallreq_i (stallreq_i),
      .stall_o    (stall_prefix)
   );

   assign redirect_pc = is_eret(excepttype_i) ? cp0_epc_i : EXC_VECTOR;
   assign exc_cause_o = cause_q;

   // exception acceptance, flush hold sequencing and output gating
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      pc_d     = pc_q;
      cause_d  = cause_q;
      stall_o  = '0;
      flush_o  = 1'b0;
      new_pc_o = '0;
      busy_o   = 1'b0;
      if (rst != RstEnable) begin
         case (state_q)
            ST_RUN: begin
               if (excepttype_i != ZeroWord) begin
                  flush_o  = 1'b1;
                  new_pc_o = redirect_pc;
                  pc_d     = redirect_pc;
                  cause_d  = excepttype_i;
                  if (FLUSH_CYCLES > 1) begin
                     state_d = ST_FLUSH;
                     cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
                  end
               end else begin
                  stall_o = stall_prefix;
               end
            end
            ST_FLUSH: begin
               flush_o  = 1'b1;
               new_pc_o = pc_q;
               busy_o   = 1'b1;
               cnt_d    = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_d = ST_RUN;
               end
            end
            default: state_d = ST_RUN;
         endcase
      end
   end

   // state, hold counter, latched redirect PC and captured cause
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         state_q <= ST_RUN;
         cnt_q   <= '0;
         pc_q    <= '0;
         cause_q <= ZeroWord;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pc_q    <= pc_d;
         cause_q <= cause_d;
      end
   end

`ifdef PIPE_CTRL_WATCHDOG_EN
   localparam int WD_W = $clog2(STALL_TIMEOUT + 1);

   logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
   logic            timeout_q, timeout_d;

   // count consecutive stalled cycles; the flag latches when the count hits the threshold
   always_comb begin
      wd_cnt_d  = wd_cnt_q;
      timeout_d = timeout_q;
      if (flush_o || (stall_o == '0)) begin
         wd_cnt_d = '0;
      end else if (wd_cnt_q != WD_W'(STALL_TIMEOUT)) begin
         wd_cnt_d = wd_cnt_q + WD_W'(1);
      end
      if (wd_cnt_d == WD_W'(STALL_TIMEOUT)) begin
         timeout_d = 1'b1;
      end
   end

   // watchdog registers
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         wd_cnt_q  <= '0;
         timeout_q <= 1'b0;
      end else begin
         wd_cnt_q  <= wd_cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign stall_timeout_o = timeout_q;
`else
   assign stall_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb/tb_pipe_ctrl_unit.sv - directed self-checking bench for pipe_ctrl_unit
module tb_pipe_ctrl_unit;

`ifdef PIPE_CTRL_WATCHDOG_EN
   localparam logic WD_ON = 1'b1;
`else
   localparam logic WD_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] exc;
   logic [31:0] epc;
   logic [5:0]  sreq;

   logic [5:0]  d1_stall, d3_stall, d4_stall;
   logic        d1_flush, d3_flush, d4_flush;
   logic [31:0] d1_pc, d3_pc, d4_pc;
   logic        d1_busy, d3_busy, d4_busy;
   logic [31:0] d1_cause, d3_cause, d4_cause;
   logic        d1_wd, d3_wd, d4_wd;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipe_ctrl_unit #(.FLUSH_CYCLES(1), .STALL_TIMEOUT(8)) u_dut1 (
      .clk(clk), .rst(rst), .excepttype_i(exc), .cp0_epc_i(epc), .stallreq_i(sreq),
      .stall_o(d1_stall), .flush_o(d1_flush), .new_pc_o(d1_pc), .busy_o(d1_busy),
      .exc_cause_o(d1_cause), .stall_timeout_o(d1_wd)
   );

   pipe_ctrl_unit #(.FLUSH_CYCLES(3), .STALL_TIMEOUT(8)) u_dut3 (
      .clk(clk), .rst(rst), .excepttype_i(exc), .cp0_epc_i(epc), .stallreq_i(sreq),
      .stall_o(d3_stall), .flush_o(d3_flush), .new_pc_o(d3_pc), .busy_o(d3_busy),
      .exc_cause_o(d3_cause), .stall_timeout_o(d3_wd)
   );

   pipe_ctrl_unit #(.FLUSH_CYCLES(4), .STALL_TIMEOUT(8)) u_dut4 (
      .clk(clk), .rst(rst), .excepttype_i(exc), .cp0_epc_i(epc), .stallreq_i(sreq),
      .stall_o(d4_stall), .flush_o(d4_flush), .new_pc_o(d4_pc), .busy_o(d4_busy),
      .exc_cause_o(d4_cause), .stall_timeout_o(d4_wd)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst  = 1'b1;
      exc  = 32'h0;
      sreq = 6'b0;
      cyc();
      rst  = 1'b0;
   endtask

   initial begin
      // 1. reset with every input active
      rst  = 1'b1;
      exc  = 32'h1;
      epc  = 32'h0000_1234;
      sreq = 6'b111111;
      for (int i = 0; i < 3; i++) begin
         cyc();
         #1;
         check("rst_stall", 64'(d1_stall), 64'd0);
         check("rst_flush", 64'(d1_flush), 64'd0);
         check("rst_pc",    64'(d1_pc),    64'd0);
         check("rst_busy",  64'(d3_busy),  64'd0);
         check("rst_cause", 64'(d1_cause), 64'd0);
         check("rst_wd",    64'(d1_wd),    64'd0);
      end
      cyc();
      rst  = 1'b0;
      exc  = 32'h0;
      sreq = 6'b0;
      #1;
      check("idle_stall", 64'(d1_stall), 64'd0);
      check("idle_busy",  64'(d3_busy),  64'd0);

      // 2. stall prefix (combinational)
      sreq = 6'b001000; #1; check("pfx_3",   64'(d1_stall), 64'(6'b001111));
      sreq = 6'b000100; #1; check("pfx_2",   64'(d1_stall), 64'(6'b000111));
      sreq = 6'b001100; #1; check("pfx_32",  64'(d1_stall), 64'(6'b001111));
      sreq = 6'b100000; #1; check("pfx_top", 64'(d1_stall), 64'(6'b111111));
      sreq = 6'b000001; #1; check("pfx_bot", 64'(d1_stall), 64'(6'b000001));
      sreq = 6'b000000; #1; check("pfx_0",   64'(d1_stall), 64'd0);

      // 3. redirect selection on the single-cycle flush instance
      cyc();
      sreq = 6'b001000;
      exc  = 32'h8;
      #1;
      check("sys_flush", 64'(d1_flush), 64'd1);
      check("sys_stall", 64'(d1_stall), 64'd0);
      check("sys_pc",    64'(d1_pc),    64'h0040_0004);
      check("sys_busy",  64'(d1_busy),  64'd0);
      cyc();
      exc  = 32'h0;
      sreq = 6'b0;
      #1;
      check("sys_cause", 64'(d1_cause), 64'h8);
      check("sys_done",  64'(d1_flush), 64'd0);
      check("sys_pc0",   64'(d1_pc),    64'd0);
      exc = 32'h0000_000e;
      epc = 32'h0040_0120;
      #1;
      check("eret_pc",    64'(d1_pc),    64'h0040_0120);
      check("eret_flush", 64'(d1_flush), 64'd1);
      cyc();
      #1;
      check("eret_cause", 64'(d1_cause), 64'he);
      exc = 32'h55;
      #1;
      check("unk_pc", 64'(d1_pc), 64'h0040_0004);
      cyc();
      exc = 32'h0;
      #1;
      check("unk_cause", 64'(d1_cause), 64'h55);
      check("unk_done",  64'(d1_flush), 64'd0);

      // 4. three-cycle flush hold
      do_reset();
      exc = 32'h1;
      #1;
      check("h3_c1_flush", 64'(d3_flush), 64'd1);
      check("h3_c1_busy",  64'(d3_busy),  64'd0);
      check("h3_c1_pc",    64'(d3_pc),    64'h0040_0004);
      cyc();
      exc  = 32'hc;
      epc  = 32'h0000_9990;
      sreq = 6'b111111;
      #1;
      check("h3_c2_flush", 64'(d3_flush), 64'd1);
      check("h3_c2_busy",  64'(d3_busy),  64'd1);
      check("h3_c2_stall", 64'(d3_stall), 64'd0);
      check("h3_c2_pc",    64'(d3_pc),    64'h0040_0004);
      check("h3_c2_cause", 64'(d3_cause), 64'h1);
      cyc();
      exc  = 32'h0;
      sreq = 6'b0;
      #1;
      check("h3_c3_flush", 64'(d3_flush), 64'd1);
      check("h3_c3_busy",  64'(d3_busy),  64'd1);
      check("h3_c3_cause", 64'(d3_cause), 64'h1);
      cyc();
      #1;
      check("h3_c4_flush", 64'(d3_flush), 64'd0);
      check("h3_c4_busy",  64'(d3_busy),  64'd0);
      exc = 32'hd;
      #1;
      check("h3_c4_acc",  64'(d3_flush), 64'd1);
      check("h3_c4_pc",   64'(d3_pc),    64'h0040_0004);
      cyc();
      exc = 32'h0;
      #1;
      check("h3_c5_cause", 64'(d3_cause), 64'hd);
      check("h3_c5_busy",  64'(d3_busy),  64'd1);
      cyc();
      cyc();
      #1;
      check("h3_end_flush", 64'(d3_flush), 64'd0);
      check("h3_end_busy",  64'(d3_busy),  64'd0);

      // 5. reset in the second cycle of a four-cycle hold
      do_reset();
      exc = 32'h1;
      #1;
      check("h4_c1_flush", 64'(d4_flush), 64'd1);
      cyc();
      exc = 32'h0;
      #1;
      check("h4_c2_busy", 64'(d4_busy), 64'd1);
      rst = 1'b1;
      #1;
      check("h4_rst_flush", 64'(d4_flush), 64'd0);
      check("h4_rst_busy",  64'(d4_busy),  64'd0);
      cyc();
      rst = 1'b0;
      #1;
      check("h4_after_flush", 64'(d4_flush), 64'd0);
      check("h4_after_busy",  64'(d4_busy),  64'd0);
      check("h4_after_cause", 64'(d4_cause), 64'd0);
      check("h4_after_pc",    64'(d4_pc),    64'd0);

      // 6. stall watchdog, threshold 8
      do_reset();
      sreq = 6'b000100;
      repeat (7) cyc();
      #1;
      check("wd_7", 64'(d1_wd), 64'd0);
      cyc();
      #1;
      check("wd_8", 64'(d1_wd), 64'(WD_ON));
      sreq = 6'b0;
      cyc();
      cyc();
      #1;
      check("wd_sticky", 64'(d1_wd), 64'(WD_ON));
      do_reset();
      #1;
      check("wd_rst", 64'(d1_wd), 64'd0);
      sreq = 6'b000100;
      repeat (7) cyc();
      sreq = 6'b0;
      cyc();
      sreq = 6'b000100;
      repeat (7) cyc();
      #1;
      check("wd_gap", 64'(d1_wd), 64'd0);
      sreq = 6'b0;
      cyc();
      #1;
      check("wd_gap_rel", 64'(d1_wd), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
